cfs_md_rx_ctrl: RTL and testbench
=================================

# cfs_md_rx_ctrl

Slave-side controller for the MD (memory data) protocol. It terminates an MD link coming from upstream, checks each transfer's offset/size legality, and flags illegal transfers with `md_err`. Legal transfers are buffered in a small show-ahead FIFO and drained by the next stage through a valid/ready pop port. It is the consumer directly downstream of the MD interface.

## Interface
- `DATA_WIDTH`, default 32: MD data width in bits; must be a power of two, ≥ 8.
- `FIFO_DEPTH`, default 8: number of transfer entries; must be a power of two, ≥ 2.
- Derived widths:
  - `BYTES = DATA_WIDTH/8`.
  - `OFFSET_WIDTH = max(1, clog2(BYTES))`.
  - `SIZE_WIDTH = clog2(BYTES)+1`.
  - `LVL_WIDTH = clog2(FIFO_DEPTH)+1`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `md_valid` in 1: upstream transfer request.
- `md_data` in `DATA_WIDTH`: transfer data.
- `md_offset` in `OFFSET_WIDTH`: byte offset of the first valid byte.
- `md_size` in `SIZE_WIDTH`: number of valid bytes.
- `md_ready` out 1: transfer accepted this cycle; registered.
- `md_err` out 1: transfer illegal; meaningful only while `md_ready`=1; registered.
- `pop_valid` out 1: FIFO not empty.
- `pop_data`, `pop_offset`, `pop_size` out: head entry; show-ahead.
- `pop_ready` in 1: downstream consumes the head entry.
- `fifo_level` out `LVL_WIDTH`: current occupancy, 0..`FIFO_DEPTH`.

## Operation
- Legality rule:
  - A transfer is legal iff `md_size` != 0 and `md_offset + md_size` ≤ `BYTES`.
  - The sum is evaluated at `SIZE_WIDTH+1` bits, so it cannot wrap.
- State machine, two states: `IDLE` and `RESP`.
  - `IDLE` → `RESP` when `md_valid`=1 and either the transfer is illegal or `fifo_level` < `FIFO_DEPTH`. Otherwise stay in `IDLE`; this is backpressure.
  - `RESP` → `IDLE` unconditionally.
  - `md_ready`=1 only in `RESP`. `md_err` is 1 in `RESP` iff the transfer is illegal.
- Push happens in `RESP` with `md_err`=0: `{data, offset, size}` is written to the FIFO tail.
- Illegal transfers are never pushed. They are acknowledged even when the FIFO is full.
- Pop happens when `pop_valid` and `pop_ready` are both 1: the head advances.
- Push and pop in the same cycle: both take effect and the level is unchanged.
- Overflow is impossible by construction: entry into `RESP` requires free space, and pops only free more.
- Pop while empty is ignored.
- Upstream protocol obligation: `md_valid`, `md_data`, `md_offset` and `md_size` stay stable from valid assertion until the `md_ready` cycle. The block does not check this.
- Pointers are `clog2(FIFO_DEPTH)` bits wide and wrap naturally. Full and empty are derived from `fifo_level`.

## Timing
- Reset values: state `IDLE`; `md_ready`=0, `md_err`=0, `pop_valid`=0, `fifo_level`=0, pointers 0. The `pop_*` data outputs are don't-care (storage is not reset).
- Latency:
  - Valid first sampled at edge N → `md_ready` high during cycle N+1.
  - A pushed entry is visible on `pop_valid` at cycle N+2.
- Throughput: at most one transfer per 2 cycles. After `RESP` the block always spends ≥1 cycle in `IDLE`.
- Backpressure release: a pop at edge M frees space; a waiting valid is sampled at edge M+1 at the earliest and gets `md_ready` in cycle M+2.
- Reset mid-transfer:
  - `md_ready` drops immediately (asynchronously).
  - The FIFO empties.
  - A transfer that was in `RESP` is lost and not pushed; upstream must re-issue it.

## Configuration
- `CFS_MD_RX_ERR_CNT_EN`: when defined, adds output `err_cnt` (16 bits).
  - Increments on every `RESP` cycle with `md_err`=1.
  - Saturates at 16'hFFFF.
  - Cleared by `reset`.
- When not defined, the port and counter are absent and behaviour is otherwise identical.

## Test plan
- Legal transfer:
  - Stimulus: `DATA_WIDTH`=32; valid with data=32'hDEADBEEF, offset=1, size=2.
  - Required: `md_ready`=1 and `md_err`=0 one cycle later; next cycle `pop_valid`=1 with identical fields and `fifo_level`=1.
- Illegal transfers:
  - Stimulus: offset=3, size=2, then offset=0, size=0.
  - Required: each acknowledged with `md_err`=1; `fifo_level` stays 0; with the macro, `err_cnt`=2.
- Full FIFO:
  - Stimulus: `pop_ready`=0; issue 9 legal transfers.
  - Required: 8 acknowledged, `fifo_level`=8, and `md_ready` held 0 on the 9th.
  - Then pulse `pop_ready` for 1 cycle: the 9th gets `md_ready` two cycles after the pop; `fifo_level` returns to 8.
- Full FIFO, illegal transfer:
  - Stimulus: with the FIFO full, issue offset=2, size=4.
  - Required: acknowledged with `md_err`=1 without any pop.
- Simultaneous push and pop:
  - Stimulus: at `fifo_level`=3, a push and a pop on the same edge.
  - Required: level stays 3; entries come out in FIFO order across ≥2 pointer wrap-arounds.
- Reset mid-transfer:
  - Stimulus: assert `reset` during a `RESP` cycle with 5 entries buffered.
  - Required: `md_ready`, `pop_valid` and `fifo_level` are 0 immediately; the first post-reset transfer behaves as the first-scenario case.

Source files
------------

// File: rtl/cfs_md_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cfs_md_rx_ctrl
// Brief    : MD slave controller that checks legality, acknowledges transfers
//            and buffers legal ones in a show-ahead FIFO with a pop port.
//            Optional macro CFS_MD_RX_ERR_CNT_EN adds a saturating err_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module cfs_md_rx_ctrl #(
    parameter int  DATA_WIDTH   = 32,
    parameter int  FIFO_DEPTH   = 8,
    localparam int BYTES        = DATA_WIDTH / 8,
    localparam int OFFSET_WIDTH = ($clog2(BYTES) >= 1) ? $clog2(BYTES) : 1,
    localparam int SIZE_WIDTH   = $clog2(BYTES) + 1,
    localparam int LVL_WIDTH    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    md_valid,
    input  logic [DATA_WIDTH-1:0]   md_data,
    input  logic [OFFSET_WIDTH-1:0] md_offset,
    input  logic [SIZE_WIDTH-1:0]   md_size,
    output logic                    md_ready,
    output logic                    md_err,
    output logic                    pop_valid,
    output logic [DATA_WIDTH-1:0]   pop_data,
    output logic [OFFSET_WIDTH-1:0] pop_offset,
    output logic [SIZE_WIDTH-1:0]   pop_size,
    input  logic                    pop_ready,
`ifdef CFS_MD_RX_ERR_CNT_EN
    output logic [15:0]             err_cnt,
`endif
    output logic [LVL_WIDTH-1:0]    fifo_level
);

    localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
    localparam int SUM_WIDTH   = SIZE_WIDTH + 1;
    localparam int ENTRY_WIDTH = DATA_WIDTH + OFFSET_WIDTH + SIZE_WIDTH;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t                 state_q;
    logic                   md_ready_q;
    logic                   md_err_q;
    logic [PTR_WIDTH-1:0]   wr_ptr_q;
    logic [PTR_WIDTH-1:0]   rd_ptr_q;
    logic [LVL_WIDTH-1:0]   level_q;
    logic [LVL_WIDTH-1:0]   level_d;
    logic [ENTRY_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [SUM_WIDTH-1:0]   w_sum;
    logic                   w_illegal;
    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;

    // One extra bit on the sum so offset+size can never wrap below BYTES.
    assign w_sum     = SUM_WIDTH'(md_offset) + SUM_WIDTH'(md_size);
    assign w_illegal = (md_size == '0) || (w_sum > SUM_WIDTH'(BYTES));
    assign w_full    = (level_q == LVL_WIDTH'(FIFO_DEPTH));
    assign w_push    = (state_q == RESP) && !md_err_q;
    assign w_pop     = (level_q != '0) && pop_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            md_ready_q <= 1'b0;
            md_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Illegal transfers never need space, so they bypass backpressure.
                    if (md_valid && (w_illegal || !w_full)) begin
                        state_q    <= RESP;
                        md_ready_q <= 1'b1;
                        md_err_q   <= w_illegal;
                    end
                end
                RESP: begin
                    state_q    <= IDLE;
                    md_ready_q <= 1'b0;
                    md_err_q   <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    md_ready_q <= 1'b0;
                    md_err_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        level_d = level_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + LVL_WIDTH'(1);
            2'b01:   level_d = level_q - LVL_WIDTH'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
            end
        end
    end

    // Inputs are held stable by upstream through the RESP cycle, so they are
    // written directly without an intermediate capture register.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {md_data, md_offset, md_size};
        end
    end

    assign {pop_data, pop_offset, pop_size} = mem_q[rd_ptr_q];
    assign pop_valid  = (level_q != '0);
    assign fifo_level = level_q;
    assign md_ready   = md_ready_q;
    assign md_err     = md_err_q;

`ifdef CFS_MD_RX_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if ((state_q == RESP) && md_err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cfs_md_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfs_md_rx_ctrl
// Brief    : Self-checking bench: queue-based reference model compared every
//            cycle, plus literal expectations for the directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfs_md_rx_ctrl;

    localparam int DEPTH = 8;
    localparam int BYTES = 4;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        md_valid  = 1'b0;
    logic [31:0] md_data   = '0;
    logic [1:0]  md_offset = '0;
    logic [2:0]  md_size   = '0;
    logic        pop_ready = 1'b0;
    logic        md_ready;
    logic        md_err;
    logic        pop_valid;
    logic [31:0] pop_data;
    logic [1:0]  pop_offset;
    logic [2:0]  pop_size;
    logic [3:0]  fifo_level;
`ifdef CFS_MD_RX_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    bit pop_rand = 1'b0;

    always #5 clk = ~clk;

    cfs_md_rx_ctrl #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .md_valid   (md_valid),
        .md_data    (md_data),
        .md_offset  (md_offset),
        .md_size    (md_size),
        .md_ready   (md_ready),
        .md_err     (md_err),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .pop_offset (pop_offset),
        .pop_size   (pop_size),
        .pop_ready  (pop_ready),
`ifdef CFS_MD_RX_ERR_CNT_EN
        .err_cnt    (err_cnt),
`endif
        .fifo_level (fifo_level)
    );

    // Reference model: a queue of buffered transfers plus the acknowledge flags.
    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  o;
        logic [2:0]  s;
    } ent_t;

    ent_t        q[$];
    logic        m_ready  = 1'b0;
    logic        m_err    = 1'b0;
    logic [15:0] m_errcnt = '0;

    function automatic bit is_illegal(input logic [1:0] o, input logic [2:0] s);
        return (s == 3'd0) || ((int'(o) + int'(s)) > BYTES);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_ready  <= 1'b0;
            m_err    <= 1'b0;
            m_errcnt <= '0;
        end else begin
            m_ready <= !m_ready && md_valid && (is_illegal(md_offset, md_size) || (q.size() < DEPTH));
            m_err   <= !m_ready && md_valid && is_illegal(md_offset, md_size);
            if (m_ready && m_err && (m_errcnt != 16'hFFFF)) begin
                m_errcnt <= m_errcnt + 16'd1;
            end
            if ((q.size() != 0) && pop_ready) begin
                q.delete(0);
            end
            if (m_ready && !m_err) begin
                q.push_back(ent_t'({md_data, md_offset, md_size}));
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("md_ready", 64'(md_ready), 64'(m_ready));
            if (m_ready) begin
                check("md_err", 64'(md_err), 64'(m_err));
            end
            check("pop_valid", 64'(pop_valid), 64'(q.size() != 0));
            check("fifo_level", 64'(fifo_level), 64'(q.size()));
            if (q.size() != 0) begin
                check("pop_data", 64'(pop_data), 64'(q[0].d));
                check("pop_offset", 64'(pop_offset), 64'(q[0].o));
                check("pop_size", 64'(pop_size), 64'(q[0].s));
            end
`ifdef CFS_MD_RX_ERR_CNT_EN
            check("err_cnt", 64'(err_cnt), 64'(m_errcnt));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_rand) begin
            pop_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] o, input logic [2:0] s);
        int n;
        n = 0;
        md_valid  = 1'b1;
        md_data   = d;
        md_offset = o;
        md_size   = s;
        while (!m_ready && (n < 100)) begin
            tick();
            n++;
        end
        check("ack_wait", 64'(m_ready), 64'(1));
        tick();
        md_valid = 1'b0;
    endtask

    task automatic scen_legal();
        md_valid  = 1'b1;
        md_data   = 32'hDEADBEEF;
        md_offset = 2'd1;
        md_size   = 3'd2;
        tick();
        check("s1_ready", 64'(md_ready), 64'(1));
        check("s1_err", 64'(md_err), 64'(0));
        tick();
        md_valid = 1'b0;
        check("s1_pop_valid", 64'(pop_valid), 64'(1));
        check("s1_pop_data", 64'(pop_data), 64'h0000_0000_DEAD_BEEF);
        check("s1_pop_offset", 64'(pop_offset), 64'(1));
        check("s1_pop_size", 64'(pop_size), 64'(2));
        check("s1_level", 64'(fifo_level), 64'(1));
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;
        check("s1_level_after_pop", 64'(fifo_level), 64'(0));
    endtask

    task automatic illegal_lit(input logic [1:0] o, input logic [2:0] s, input int lvl);
        md_valid  = 1'b1;
        md_data   = 32'h0BAD_0000 | 32'(o);
        md_offset = o;
        md_size   = s;
        tick();
        check("ill_ready", 64'(md_ready), 64'(1));
        check("ill_err", 64'(md_err), 64'(1));
        tick();
        md_valid = 1'b0;
        check("ill_level", 64'(fifo_level), 64'(lvl));
    endtask

    initial begin
        #100_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] o;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(md_ready), 64'(0));
        check("rst_pop_valid", 64'(pop_valid), 64'(0));
        check("rst_level", 64'(fifo_level), 64'(0));
        reset = 1'b0;
        tick();

        scen_legal();

        illegal_lit(2'd3, 3'd2, 0);
        illegal_lit(2'd0, 3'd0, 0);
`ifdef CFS_MD_RX_ERR_CNT_EN
        check("err_cnt_two", 64'(err_cnt), 64'(2));
`endif

        for (int i = 0; i < DEPTH; i++) begin
            send(32'hA000_0000 + 32'(i), 2'd0, 3'd4);
        end
        check("full_level", 64'(fifo_level), 64'(8));
        md_valid  = 1'b1;
        md_data   = 32'hA000_0008;
        md_offset = 2'd0;
        md_size   = 3'd4;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_hold", 64'(md_ready), 64'(0));
        end
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;
        check("bp_after_pop", 64'(md_ready), 64'(0));
        tick();
        check("bp_release", 64'(md_ready), 64'(1));
        tick();
        md_valid = 1'b0;
        check("bp_level", 64'(fifo_level), 64'(8));

        illegal_lit(2'd2, 3'd4, 8);

        pop_ready = 1'b1;
        repeat (DEPTH) tick();
        pop_ready = 1'b0;
        check("drain_level", 64'(fifo_level), 64'(0));

        for (int i = 0; i < 3; i++) begin
            send(32'hC000_0000 + 32'(i), 2'd1, 3'd3);
        end
        for (int k = 0; k < 20; k++) begin
            o         = 2'($urandom_range(0, 3));
            md_valid  = 1'b1;
            md_data   = $urandom;
            md_offset = o;
            md_size   = 3'($urandom_range(1, BYTES - int'(o)));
            tick();
            pop_ready = 1'b1;
            tick();
            pop_ready = 1'b0;
            md_valid  = 1'b0;
            check("pp_level", 64'(fifo_level), 64'(3));
        end
        pop_ready = 1'b1;
        repeat (3) tick();
        pop_ready = 1'b0;

        pop_rand = 1'b1;
        for (int k = 0; k < 300; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            send($urandom, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 5)));
        end
        pop_rand  = 1'b0;
        pop_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        pop_ready = 1'b0;

        for (int i = 0; i < 5; i++) begin
            send(32'hE000_0000 + 32'(i), 2'd0, 3'd1);
        end
        md_valid  = 1'b1;
        md_data   = 32'hE000_0005;
        md_offset = 2'd0;
        md_size   = 3'd1;
        tick();
        check("mid_in_resp", 64'(md_ready), 64'(1));
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 64'(md_ready), 64'(0));
        check("mid_rst_pop_valid", 64'(pop_valid), 64'(0));
        check("mid_rst_level", 64'(fifo_level), 64'(0));
        md_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        scen_legal();

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
